// File: rtl/srambank_param.sv
// srambank_param: parametrised single-port SRAM leaf bank with per-lane write mask and power-up clear.
// Latency: read data 1 cycle after request (OUT_REG=0) or 2 cycles (OUT_REG=1); writes complete on the request edge.
// Backpressure: none per access; busy is high for WORDS cycles after reset while the bank zeroes itself, and requests are dropped then.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   ADDRESS, wd, wmask   word address, write data, per-lane write enables
//   banksel, read, write access enable and request type (write wins over read)
//   dataout, dvalid      read data (held between reads), one-cycle valid pulse
//   busy                 clear sequence in progress
//   rw_conflict          registered pulse: read and write requested together
//   parity_err           only with SRAMBANK_PARITY_EN: returned word failed lane parity
//
// Optional feature macro: SRAMBANK_PARITY_EN adds one even-parity bit per lane and the parity_err port.
module srambank_param #(
  parameter int WORDS      = 512,
  parameter int WIDTH      = 20,
  parameter int LANE       = 4,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(WORDS)-1:0] ADDRESS,
  input  logic [WIDTH-1:0]         wd,
  input  logic [WIDTH/LANE-1:0]    wmask,
  input  logic                     banksel,
  input  logic                     read,
  input  logic                     write,
  output logic [WIDTH-1:0]         dataout,
  output logic                     dvalid,
  output logic                     busy,
  output logic                     rw_conflict
`ifdef SRAMBANK_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int AW = $clog2(WORDS);
  localparam int NL = WIDTH / LANE;
`ifdef SRAMBANK_PARITY_EN
  localparam int PW = WIDTH + 1;  // read payload carries the parity-error flag on top
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;

  state_t        state, state_nx;
  logic [AW-1:0] clr_cnt, clr_cnt_nx;

  logic [WIDTH-1:0] mem [WORDS];
`ifdef SRAMBANK_PARITY_EN
  logic [NL-1:0]    par_mem [WORDS];
`endif

  logic          wr_en, rd_en, conf_en;
  logic [PW-1:0] rd_pay;
  logic [PW-1:0] out_pay;
  logic          out_vld;

  // Clear FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Counter wraps to 0 naturally on the last word because WORDS is a power of 2.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    busy       = 1'b0;
    case (state)
      S_CLEAR: begin
        busy       = 1'b1;
        clr_cnt_nx = clr_cnt + AW'(1);
        if (clr_cnt == AW'(WORDS - 1)) state_nx = S_RUN;
      end
      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  assign wr_en   = (state == S_RUN) && banksel && write;
  assign rd_en   = (state == S_RUN) && banksel && read && !write;
  assign conf_en = (state == S_RUN) && banksel && read && write;

  // Storage array: not reset, zeroed by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
`ifdef SRAMBANK_PARITY_EN
      par_mem[clr_cnt] <= '0;
`endif
    end else if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) begin
          mem[ADDRESS][i*LANE +: LANE] <= wd[i*LANE +: LANE];
`ifdef SRAMBANK_PARITY_EN
          par_mem[ADDRESS][i] <= ^wd[i*LANE +: LANE];
`endif
        end
      end
    end
  end

`ifdef SRAMBANK_PARITY_EN
  logic [WIDTH-1:0] rd_word;
  logic             rd_perr;
  assign rd_word = mem[ADDRESS];
  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NL; i++) begin
      rd_perr = rd_perr | ((^rd_word[i*LANE +: LANE]) ^ par_mem[ADDRESS][i]);
    end
  end
  assign rd_pay = {rd_perr, rd_word};
`else
  assign rd_pay = mem[ADDRESS];
`endif

  // Read return path; the optional stage delays both data and valid by one edge.
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [PW-1:0] pipe_pay;
      logic          pipe_vld;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_pay <= '0;
          pipe_vld <= 1'b0;
          out_pay  <= '0;
          out_vld  <= 1'b0;
        end else begin
          pipe_vld <= rd_en;
          if (rd_en) pipe_pay <= rd_pay;
          out_vld <= pipe_vld;
          if (pipe_vld) out_pay <= pipe_pay;
        end
      end
    end else begin : g_noreg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_pay <= '0;
          out_vld <= 1'b0;
        end else begin
          out_vld <= rd_en;
          if (rd_en) out_pay <= rd_pay;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rw_conflict <= 1'b0;
    else          rw_conflict <= conf_en;
  end

  assign dataout = out_pay[WIDTH-1:0];
  assign dvalid  = out_vld;
`ifdef SRAMBANK_PARITY_EN
  // The flag stays in out_pay between reads, so qualify it with the valid pulse.
  assign parity_err = out_vld & out_pay[WIDTH];
`endif

endmodule

// File: doc/srambank_param.md
Name: srambank_param

Overview:
- Parametrised synchronous single-port SRAM bank model; next generation of the fixed 128x4x20 bank macros.
- Generalised in depth and width, with a per-lane write mask and an optional output pipeline register.
- Adds a power-up clear state machine and a read/write collision flag.
- Sits behind the bank decoder as one leaf bank in the SRAM array.

Parameters:
- WORDS, 512, number of words; power of 2, >= 2.
- WIDTH, 20, data bits per word.
- LANE, 4, bits per write-mask lane; WIDTH must be a multiple of LANE.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- INIT_CLEAR, 1, 1 = zero every word after reset before accepting accesses; 0 = ready immediately.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ADDRESS  in  $clog2(WORDS)  word address.
- wd  in  WIDTH  write data.
- wmask  in  WIDTH/LANE  lane write enables; 1 = write that lane.
- banksel  in  1  access enable.
- read  in  1  read request.
- write  in  1  write request.
- dataout  out  WIDTH  read data; held until the next read completes.
- dvalid  out  1  one-cycle pulse when dataout takes new read data.
- busy  out  1  high while the clear sequence runs; accesses ignored.
- rw_conflict  out  1  one-cycle pulse, registered: read and write were requested together.

Behaviour:
- Reset (reset_n low, asynchronous): dataout=0, dvalid=0, rw_conflict=0, pipeline register=0.
- Reset sets busy=1 if INIT_CLEAR=1, else busy=0.
- Reset sets the clear counter to 0 and the FSM state to CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
- Memory contents are not reset asynchronously.
- FSM CLEAR: each cycle writes all-zero to mem[counter] and increments the counter.
  - When counter = WORDS-1 is written: counter wraps to 0, busy falls on that edge, state becomes RUN.
  - Total: busy high for exactly WORDS cycles after reset release.
  - All request inputs are ignored: no write, no dvalid, no rw_conflict.
- FSM RUN: accepted access = banksel & (read | write).
  - write & banksel: for each lane i with wmask[i]=1, mem[ADDRESS][i*LANE +: LANE] <= wd lane i; other lanes unchanged.
  - write with wmask=0: no change to memory, not an error.
  - read & banksel & !write: memory word read.
    - OUT_REG=0: dataout and dvalid updated on the same edge (latency 1).
    - OUT_REG=1: word captured into the pipeline register; dataout and dvalid follow one edge later (latency 2).
  - read & write & banksel: write wins; no read is performed; dvalid stays 0; rw_conflict=1 for the next cycle.
  - banksel=0: nothing happens; dataout holds.
  - Back-to-back reads every cycle: full throughput; dvalid high continuously.
- dataout is never changed by writes; a read issued after a write returns the new value.
- Reset asserted mid-CLEAR: the sequence restarts from address 0.
- Reset asserted with a read in the OUT_REG pipeline: the read is discarded.
- ADDRESS must be in range; out-of-range addresses are impossible by construction.

Optional Feature:
- Macro: SRAMBANK_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, written with the lane and cleared to correct parity (0) by CLEAR.
  - Extra output port parity_err (1 bit, reset 0) is asserted alongside dvalid when any lane of the returned word fails parity.
  - Data is returned unmodified.
- Not defined: no parity storage and no parity_err port.

Test Plan:
- INIT_CLEAR=1, WORDS=512: release reset -> busy high exactly 512 cycles; then read ADDRESS=0x1FF -> dataout=0, dvalid pulse.
- Write ADDRESS=5, wd=0xABCDE, wmask=11111b; then write wd=0x00000, wmask=00010b; read 5 -> dataout=0xABC0E.
- OUT_REG=1: reads at addresses 1, 2, 3 on consecutive cycles -> data appears 2 cycles after each request, with dvalid high for 3 consecutive cycles.
- read=write=banksel=1 at ADDRESS=7 with wd=0x12345 -> next cycle rw_conflict=1, dvalid=0, dataout unchanged; a later read of 7 returns 0x12345.
- Pulse reset_n low at clear count 100 -> busy stays high; clear restarts at 0 and busy drops 512 cycles after the second release.
- SRAMBANK_PARITY_EN: force a flip of stored bit 3 of address 9, then read 9 -> parity_err=1 with dvalid; a read of an intact address gives parity_err=0.
